saturn_bus_arbiter: RTL

// - Shares the single 4-phase Saturn nibble bus between two requesters:
//   req 0 = control unit program stream, req 1 = debugger/monitor stream.
// - Grants whole transactions, switching owner only on bus-cycle boundaries.
// - Issues at most one command/data nibble, or one read, per 4-phase cycle.
// - Sits between the requesters and the bus pins (o_bus_clk_en/is_data/nibble_out).
//

---
 rtl/saturn_bus_pkg.sv | 17 +
 rtl/saturn_rr_arbiter.sv | 25 ++
 rtl/saturn_bus_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/saturn_bus_pkg.sv
// Shared constants and state encodings for the Saturn nibble-bus arbiter.
package saturn_bus_pkg;

  localparam logic [3:0] PH_SEND   = 4'b0001;
  localparam logic [3:0] PH_READ   = 4'b0010;
  localparam logic [3:0] PH_DECODE = 4'b0100;
  localparam logic [3:0] PH_EXEC   = 4'b1000;

  localparam int CMD_BIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

endpackage

// File: rtl/saturn_rr_arbiter.sv
// Two-way combinational pick: fixed debugger priority or round-robin on ties.
module saturn_rr_arbiter #(
  parameter bit DBG_PRIORITY = 1'b0
) (
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    unique case (i_req)
      2'b01: o_grant = 2'b01;
      2'b10: o_grant = 2'b10;
      2'b11: begin
        if (DBG_PRIORITY)
          o_grant = 2'b10;
        else
          o_grant = i_last_owner ? 2'b01 : 2'b10;
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/saturn_bus_arbiter.sv
// Saturn nibble-bus arbiter: whole-transaction ownership, one bus
// transfer per 4-phase cycle, owner changes only on the exec phase.
module saturn_bus_arbiter
  import saturn_bus_pkg::*;
#(
  parameter bit DBG_PRIORITY = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clk_en,
  input  logic [3:0] i_phases,
  input  logic [1:0] i_req,
  input  logic [4:0] i_prog_0,
  input  logic [4:0] i_prog_1,
  input  logic [1:0] i_prog_valid,
  output logic [1:0] o_prog_ready,
  input  logic [1:0] i_read,
  output logic [1:0] o_grant,
  output logic       o_bus_clk_en,
  output logic       o_bus_is_data,
  output logic [3:0] o_bus_nibble_out,
  input  logic [3:0] i_bus_nibble_in,
  output logic [3:0] o_nibble_in,
  output logic [1:0] o_nibble_valid,
  output logic       o_busy
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last;
  logic       w_rel;
  logic       w_rel_id;
  logic       w_arb_last;
  logic [1:0] w_pick;
  logic       w_exec;

  logic       r_bus_clk_en;
  logic       r_is_data;
  logic [3:0] r_nib_out;
  logic [3:0] r_nib_in;
  logic [1:0] r_nib_vld;
  logic [1:0] r_prog_rdy;
  logic       r_busy;
  logic       r_rd_pend;

  logic       w_own_vld;
  logic       w_own;
  logic [4:0] w_prog;
  logic       w_pvalid;
  logic       w_rd;

  assign w_exec = i_clk_en && (i_phases == PH_EXEC);

  saturn_rr_arbiter #(
    .DBG_PRIORITY (DBG_PRIORITY)
  ) u_rr (
    .i_req        (i_req),
    .i_last_owner (w_arb_last),
    .o_grant      (w_pick)
  );

  // A releasing owner becomes last_owner before the same-edge re-arbitration.
  always_comb begin
    w_rel    = 1'b0;
    w_rel_id = r_last;
    unique case (r_state)
      ST_OWN0: if (!i_req[0]) begin
        w_rel    = 1'b1;
        w_rel_id = 1'b0;
      end
      ST_OWN1: if (!i_req[1]) begin
        w_rel    = 1'b1;
        w_rel_id = 1'b1;
      end
      default: ;
    endcase
    w_arb_last  = w_rel ? w_rel_id : r_last;
    w_state_nxt = r_state;
    if (r_state == ST_IDLE || w_rel) begin
      unique case (1'b1)
        w_pick[0]: w_state_nxt = ST_OWN0;
        w_pick[1]: w_state_nxt = ST_OWN1;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else if (w_exec) begin
      r_state <= w_state_nxt;
      r_last  <= w_arb_last;
    end
  end

  assign w_own_vld = (r_state != ST_IDLE);
  assign w_own     = (r_state == ST_OWN1);
  assign w_prog    = w_own ? i_prog_1 : i_prog_0;
  assign w_pvalid  = w_own_vld && i_prog_valid[w_own];
  assign w_rd      = w_own_vld && i_read[w_own];

  // Pulses clear on every edge regardless of the clock enable.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bus_clk_en <= 1'b0;
      r_is_data    <= 1'b0;
      r_nib_out    <= 4'h0;
      r_nib_in     <= 4'h0;
      r_nib_vld    <= 2'b00;
      r_prog_rdy   <= 2'b00;
      r_busy       <= 1'b0;
      r_rd_pend    <= 1'b0;
    end else begin
      r_nib_vld  <= 2'b00;
      r_prog_rdy <= 2'b00;
      if (i_clk_en) begin
        unique case (i_phases)
          PH_SEND: begin
            if (w_pvalid) begin
              r_nib_out          <= w_prog[3:0];
              r_is_data          <= !w_prog[CMD_BIT];
              r_bus_clk_en       <= 1'b1;
              r_busy             <= 1'b1;
              r_prog_rdy[w_own]  <= 1'b1;
            end else if (w_rd) begin
              r_bus_clk_en <= 1'b1;
              r_busy       <= 1'b1;
              r_rd_pend    <= 1'b1;
            end
          end
          PH_READ: begin
            r_bus_clk_en <= 1'b0;
            if (r_rd_pend) begin
              r_nib_in         <= i_bus_nibble_in;
              r_nib_vld[w_own] <= 1'b1;
              r_rd_pend        <= 1'b0;
            end
          end
          PH_DECODE: r_busy <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign o_grant          = r_state;
  assign o_bus_clk_en     = r_bus_clk_en;
  assign o_bus_is_data    = r_is_data;
  assign o_bus_nibble_out = r_nib_out;
  assign o_nibble_in      = r_nib_in;
  assign o_nibble_valid   = r_nib_vld;
  assign o_prog_ready     = r_prog_rdy;
  assign o_busy           = r_busy;

endmodule
